// File: rtl/i2c_init_seq_pkg.sv
// Shared types and constants for the I2C init write-sequence engine.
package i2c_init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_FIN
    } state_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam int unsigned WRITE_TICKS = 116;
    localparam logic        I2C_WR      = 1'b0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } init_cmd_t;

    // Open-drain pull-downs {sda_oe, scl_oe} for a given state and quarter-bit phase.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] qtr,
                                             input logic bit_val);
        logic sda;
        logic scl;
        sda = 1'b0;
        scl = 1'b0;
        case (st)
            ST_START: begin
                sda = (qtr >= T2);
                scl = (qtr == T3);
            end
            ST_BYTE: begin
                sda = ~bit_val;
                scl = (qtr <= T1);
            end
            ST_ACK: begin
                scl = (qtr <= T1);
            end
            ST_STOP: begin
                sda = (qtr <= T1);
                scl = (qtr == T0);
            end
            default: begin
                sda = 1'b0;
                scl = 1'b0;
            end
        endcase
        return {sda, scl};
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Pixart camera bring-up table: maps an entry index to its {register, data} pair.
module i2c_init_rom
    import i2c_init_seq_pkg::*;
#(
    parameter int unsigned IW = 2
) (
    input  logic [IW-1:0] idx,
    output init_cmd_t     cmd_c
);

    always_comb begin
        cmd_c = '0;
        case (32'(idx))
            32'd0:   cmd_c = '{reg_addr: 8'h30, data: 8'h01};
            32'd1:   cmd_c = '{reg_addr: 8'h30, data: 8'h08};
            32'd2:   cmd_c = '{reg_addr: 8'h06, data: 8'h90};
            32'd3:   cmd_c = '{reg_addr: 8'h08, data: 8'hC0};
            default: cmd_c = '0;
        endcase
    end

endmodule

// File: rtl/i2c_init_seq.sv
// I2C register-write sequencer: open-drain bus, per-write ACK checking with retries,
// quarter-bit tick divider on the system clock.
module i2c_init_seq
    import i2c_init_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 60,
    parameter int unsigned NUM_WRITES = 4,
    parameter logic [6:0]  DEV_ADDR   = 7'h58,
    parameter int unsigned GAP_TICKS  = 16,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned IW         = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [IW-1:0] cmd_idx,
    input  logic [7:0]    cmd_reg,
    input  logic [7:0]    cmd_data,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          scl_oe,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] err_idx
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           qtr_q, qtr_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [2:0]           bit_q, bit_d;
    logic [1:0]           byte_q, byte_d;
    logic [7:0]           tx_q, tx_d;
    logic [15:0]          hold_q, hold_d;
    logic                 nack_q, nack_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 start_q;
    logic [IW-1:0]        cmd_idx_d, err_idx_d;
    logic                 sda_oe_d, scl_oe_d, busy_d, done_d, error_d;
    logic                 tick, phase_end;
    logic [RETRY_W-1:0]   retry_inc;

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign phase_end = tick && (qtr_q == T3);
    assign retry_inc = retry_q + RETRY_W'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        hold_d    = hold_q;
        nack_d    = nack_q;
        retry_d   = retry_q;
        cmd_idx_d = cmd_idx;
        busy_d    = busy;
        done_d    = done;
        error_d   = error;
        err_idx_d = err_idx;

        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !start_q) begin
                    state_d   = ST_START;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    cmd_idx_d = '0;
                    retry_d   = '0;
                end
            end
            ST_START: begin
                // table bytes are captured once, on the first cycle after cmd_idx settles
                if (div_q == '0 && qtr_q == T0) hold_d = {cmd_reg, cmd_data};
                nack_d = 1'b0;
                if (phase_end) begin
                    state_d = ST_BYTE;
                    tx_d    = {DEV_ADDR, I2C_WR};
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            ST_BYTE: begin
                if (phase_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = tx_q << 1;
                    end
                end
            end
            ST_ACK: begin
                if (tick && qtr_q == T2) nack_d = sda_in;
                if (phase_end) begin
                    if (nack_q || byte_q == 2'd2) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_BYTE;
                        bit_d   = '0;
                        byte_d  = byte_q + 2'd1;
                        tx_d    = (byte_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
                    end
                end
            end
            ST_STOP: begin
                if (phase_end) begin
                    if (nack_q) begin
                        retry_d = retry_inc;
                        if (32'(retry_inc) <= MAX_RETRY) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d   = ST_FIN;
                            error_d   = 1'b1;
                            err_idx_d = cmd_idx;
                            busy_d    = 1'b0;
                        end
                    end else if (cmd_idx == IW'(NUM_WRITES - 1)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_GAP;
                        gap_d     = '0;
                        cmd_idx_d = cmd_idx + IW'(1);
                        retry_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_W'(GAP_TICKS - 1)) state_d = ST_START;
                    else gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // every state starts on a clean tick boundary
        if (state_d != state_q) begin
            div_d = '0;
            qtr_d = T0;
        end

        {sda_oe_d, scl_oe_d} = bus_drive(state_d, qtr_d, tx_d[7]);
    end

    always_ff @(posedge clk) begin
        start_q <= start;
        if (!reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            qtr_q   <= T0;
            gap_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            hold_q  <= '0;
            nack_q  <= 1'b0;
            retry_q <= '0;
            cmd_idx <= '0;
            err_idx <= '0;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            hold_q  <= hold_d;
            nack_q  <= nack_d;
            retry_q <= retry_d;
            cmd_idx <= cmd_idx_d;
            err_idx <= err_idx_d;
            sda_oe  <= sda_oe_d;
            scl_oe  <= scl_oe_d;
            busy    <= busy_d;
            done    <= done_d;
            error   <= error_d;
        end
    end

endmodule

// File: doc/i2c_init_seq.md
# i2c_init_seq

Parametrised I2C write-sequence engine, successor to the fixed `i2c_init` block. It replaces the divided-`slow_clk` scheme: it runs on the system clock with an internal quarter-bit tick divider. On each `start` rising edge it issues NUM_WRITES single-byte register writes (device address, register, data) to one 7-bit slave, which brings up the Pixart camera. Unlike its predecessor it drives SDA and SCL open-drain, checks every ACK, retries NACKed writes, and reports busy, done and error.

## Interface
- `CLK_DIV`, 60: `clk` cycles per quarter-bit tick; legal range ≥ 2.
- `NUM_WRITES`, 4: entries in the write table; legal range ≥ 1.
- `DEV_ADDR`, 7'h58: 7-bit slave address; R/W bit is always 0 (write).
- `GAP_TICKS`, 16: idle ticks between writes and before a retry.
- `MAX_RETRY`, 3: retries per entry after a NACK before declaring an error.
- `IW`: table index width, max(1, clog2(NUM_WRITES)).

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `start` in 1: sequence trigger, already debounced; only its rising edge acts.
- `cmd_idx` out IW: table entry currently requested.
- `cmd_reg` in 8: register byte for `cmd_idx`; combinational from the table.
- `cmd_data` in 8: data byte for `cmd_idx`.
- `sda_in` in 1: SDA pin level.
- `sda_oe` out 1: 1 pulls SDA low, 0 releases it.
- `scl_oe` out 1: 1 pulls SCL low, 0 releases it.
- `busy` out 1: sequence in progress.
- `done` out 1: last sequence completed with every write ACKed; sticky.
- `error` out 1: last sequence aborted after retries ran out; sticky.
- `err_idx` out IW: entry that failed; valid while `error` = 1.

## Operation
- Reset (`reset` = 0) sets all outputs to 0, including `sda_oe`, `scl_oe` and `cmd_idx`, and the state to IDLE. This applies mid-transfer too: the bus is released immediately and no recovery is attempted.
- States are IDLE, START, BYTE, ACK, STOP, GAP and FIN.
- **IDLE:** a `start` rising edge (registered previous value, detected in the same cycle) clears `done`, `error` and `cmd_idx`, then enters START. `start` edges outside IDLE are ignored.
- **START:** latches `cmd_reg` and `cmd_data` into a 2-byte shift buffer, then emits the START condition.
- **BYTE/ACK:** sends bytes in the order {DEV_ADDR,0}, cmd_reg, cmd_data, MSB first. Each byte is followed by an ACK bit with SDA released.
  - ACK (`sda_in` = 0) advances to the next byte, or to STOP after the third byte.
  - NACK goes straight to STOP with the NACK flag set.
- **STOP:** emits the STOP condition. Next state:
  - NACK flag set: increment the retry count. If the count ≤ MAX_RETRY, go to GAP and repeat the same entry. Otherwise set `error`, set `err_idx` = `cmd_idx`, and go to FIN.
  - Clean write, and `cmd_idx` = NUM_WRITES−1: set `done` and go to FIN.
  - Clean write otherwise: increment `cmd_idx`, clear the retry count, go to GAP.
- **GAP:** both lines released for GAP_TICKS ticks, then START.
- **FIN:** clears `busy` and returns to IDLE next cycle.
- `busy` = 1 from the cycle after the `start` edge until FIN.

## Timing
- A tick is CLK_DIV `clk` cycles. The tick counter resets on every state entry, so phase boundaries are exact.
- Each phase is 4 ticks, t0 to t3.
- START: t0–t1 SDA and SCL released; t2 SDA low; t3 SDA and SCL low.
- Data/ACK bit:
  - t0: SCL low, `sda_oe` updated to the new bit.
  - t1: SCL low.
  - t2: SCL released; at the last `clk` of t2, `sda_in` is sampled for ACK.
  - t3: SCL released.
- STOP: t0 SDA and SCL low; t1 SCL released; t2–t3 both released.
- SDA changes only while SCL is held low, except at START and STOP.
- One write = 4 + 27×4 + 4 = 116 ticks. A clean sequence lasts (116·N + GAP_TICKS·(N−1))·CLK_DIV cycles from `busy` rising to `done` rising.
- `cmd_*` inputs are read only at START entry. They must be stable for one cycle after `cmd_idx` changes.

## Structure
- Shared package/include holds the state encoding, the phase constants T0–T3, the 116-tick write length, and the I2C_WR = 0 bit.
- Sub-module `i2c_init_rom`: combinational table mapping `cmd_idx` to {reg, data}. Default Pixart table: 30/01, 30/08, 06/90, 08/C0. Instantiated beside the block, not inside it.
- The pad tristates (pull-low when `*_oe` = 1) sit at the top level.

## Test plan
- CLK_DIV=2, default table, slave model ACKs everything; pulse `start` → 4 writes decoded as 58W 30 01, 58W 30 08, 58W 06 90, 58W 08 C0; `done`=1 and `busy` falls after exactly (464+48)·2 = 1024 cycles.
- Slave NACKs the data byte of entry 1 twice, then ACKs → entry 1 sent 3 times with 16-tick gaps; `done`=1, `error`=0.
- Slave NACKs the address forever → entry 0 sent 4 times (1 + MAX_RETRY); `error`=1, `err_idx`=0, `done`=0, bus released.
- `start` toggled while `busy` → no extra transfer; after `done`, a new edge clears `done` and reruns the sequence.
- `reset`=0 asserted mid-byte for 1 cycle → next cycle `sda_oe`=`scl_oe`=`busy`=0; `start` held high with no new edge does not relaunch.
- Bus-protocol checker over all scenarios: SDA never changes while SCL is released, except at START/STOP; every ACK sample lands within the SCL-released window.
